// File: rtl/aes_sbox_scheduler.sv
// Shares LANES forward AES S-box lanes between the round datapath (16-byte SubBytes
// over 16/LANES passes) and key expansion (4-byte SubWord in one pass), round-robin.

module aes_sbox_lane (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Byte i of the table lives at bits [8*(255-i) +: 8]; 255-i is simply ~i.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX[{~in_i, 3'b000} +: 8];
endmodule

module aes_sbox_scheduler #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [31:0]  key_in,
  output logic [31:0]  key_out,
  output logic         key_done,
  output logic         busy,
  output logic [1:0]   dbg_state
);
  localparam int P  = 16 / LANES;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_ST  = 2'd1,
    RUN_KEY = 2'd2
  } state_e;

  localparam logic GRANT_ST  = 1'b0;
  localparam logic GRANT_KEY = 1'b1;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            last_grant_q;
  logic [127:0]    st_q;
  logic [31:0]     key_q;
  logic [127:0]    st_out_q;
  logic [127:0]    st_out_d;
  logic [31:0]     key_out_q;
  logic            st_done_q;
  logic            key_done_q;
  logic            idle;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];
  logic [31:0]     key_word;

  // Valid/ready: a request is taken on the edge where valid & ready are both high;
  // ready is only offered in IDLE, to one requester at a time, never the last winner on a tie.
  assign idle      = (state_q == IDLE);
  assign st_ready  = idle & st_valid  & (~key_valid | (last_grant_q == GRANT_KEY));
  assign key_ready = idle & key_valid & (~st_valid  | (last_grant_q == GRANT_ST));

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = 8'h00;
      for (int p = 0; p < P; p++) begin
        if (cnt_q == CW'(p)) lane_in[l] = st_q[127 - 8*(p*LANES + l) -: 8];
      end
      if (state_q == RUN_KEY && l < 4) lane_in[l] = key_q[31 - 8*l -: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lane u_lane (
      .in_i  (lane_in[l]),
      .out_o (lane_out[l])
    );
  end

  // Only the bytes belonging to the current pass are replaced.
  always_comb begin
    st_out_d = st_out_q;
    for (int p = 0; p < P; p++) begin
      for (int l = 0; l < LANES; l++) begin
        if (cnt_q == CW'(p)) st_out_d[127 - 8*(p*LANES + l) -: 8] = lane_out[l];
      end
    end
  end

  assign key_word = {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_ST;
      st_q         <= '0;
      key_q        <= '0;
      st_out_q     <= '0;
      key_out_q    <= '0;
      st_done_q    <= 1'b0;
      key_done_q   <= 1'b0;
    end else begin
      st_done_q  <= 1'b0;
      key_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_ready) begin
            key_q        <= key_in;
            last_grant_q <= GRANT_KEY;
            state_q      <= RUN_KEY;
          end else if (st_ready) begin
            st_q         <= st_in;
            last_grant_q <= GRANT_ST;
            cnt_q        <= '0;
            state_q      <= RUN_ST;
          end
        end
        RUN_ST: begin
          st_out_q <= st_out_d;
          if (cnt_q == CW'(P - 1)) begin
            cnt_q     <= '0;
            st_done_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN_KEY: begin
          key_out_q  <= key_word;
          key_done_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign st_out    = st_out_q;
  assign key_out   = key_out_q;
  assign st_done   = st_done_q;
  assign key_done  = key_done_q;
  assign busy      = ~idle;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Bench for aes_sbox_scheduler: LANES = 4, 8 and 16 side by side, exercised one at a time
// against an S-box model derived from GF(2^8) inversion plus the affine map.

module tb_aes_sbox_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   st_valid, key_valid, st_ready, key_ready, st_done, key_done, busy;
  logic [127:0] st_in  [3];
  logic [127:0] st_out [3];
  logic [31:0]  key_in [3];
  logic [31:0]  key_out[3];
  logic [1:0]   dbg_state[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_sbox_scheduler #(.LANES(4 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid[g]),
      .st_ready  (st_ready[g]),
      .st_in     (st_in[g]),
      .st_out    (st_out[g]),
      .st_done   (st_done[g]),
      .key_valid (key_valid[g]),
      .key_ready (key_ready[g]),
      .key_in    (key_in[g]),
      .key_out   (key_out[g]),
      .key_done  (key_done[g]),
      .busy      (busy[g]),
      .dbg_state (dbg_state[g])
    );
  end

  int           n_checks = 0;
  int           n_pass   = 0;
  int           cur_g    = 0;
  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_st;
  logic [31:0]  exp_key;
  logic [31:0]  exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] s = x;
    logic [7:0] r = x;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = affine(inv);
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] d);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[127 - 8*b -: 8] = sbox_ref[d[127 - 8*b -: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[31 - 8*b -: 8] = sbox_ref[d[31 - 8*b -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] b(input logic x);
    return {127'd0, x};
  endfunction

  function automatic logic [127:0] w(input logic [31:0] x);
    return {96'd0, x};
  endfunction

  function automatic int passes();
    return 4 >> cur_g;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s (LANES=%0d) got %h expected %h", tag, 4 << cur_g, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_st_out",   st_out[cur_g], 0);
    check("rst_key_out",  w(key_out[cur_g]), 0);
    check("rst_busy",     b(busy[cur_g]), 0);
    check("rst_st_done",  b(st_done[cur_g]), 0);
    check("rst_key_done", b(key_done[cur_g]), 0);
    exp_st  = '0;
    exp_key = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_st_done();
    for (int k = 1; k <= passes(); k++) begin
      check("st_busy", b(busy[cur_g]), 1);
      check("st_done_early", b(st_done[cur_g]), 0);
      step();
    end
    check("st_done",      b(st_done[cur_g]), 1);
    check("st_out",       st_out[cur_g], exp_st);
    check("st_idle",      b(busy[cur_g]), 0);
    check("key_out_hold", w(key_out[cur_g]), w(exp_key));
  endtask

  task automatic wait_key_done();
    check("key_busy", b(busy[cur_g]), 1);
    check("key_done_early", b(key_done[cur_g]), 0);
    step();
    exp_key = exp_q.pop_front();
    check("key_done",    b(key_done[cur_g]), 1);
    check("key_out",     w(key_out[cur_g]), w(exp_key));
    check("st_out_hold", st_out[cur_g], exp_st);
    check("key_idle",    b(busy[cur_g]), 0);
  endtask

  task automatic run_state(input logic [127:0] d);
    st_valid[cur_g] = 1'b1;
    st_in[cur_g]    = d;
    #1;
    check("st_ready", b(st_ready[cur_g]), 1);
    check("st_excl",  b(key_ready[cur_g]), 0);
    step();
    st_valid[cur_g] = 1'b0;
    st_in[cur_g]    = rand128();
    exp_st = sub_state(d);
    wait_st_done();
  endtask

  task automatic run_key(input logic [31:0] d);
    key_valid[cur_g] = 1'b1;
    key_in[cur_g]    = d;
    #1;
    check("key_ready", b(key_ready[cur_g]), 1);
    check("key_excl",  b(st_ready[cur_g]), 0);
    step();
    key_valid[cur_g] = 1'b0;
    key_in[cur_g]    = $urandom;
    exp_q.push_back(sub_word(d));
    wait_key_done();
  endtask

  task automatic rr_pair(input logic key_first);
    logic [127:0] sd = rand128();
    logic [31:0]  kd = $urandom;
    st_valid[cur_g]  = 1'b1;
    st_in[cur_g]     = sd;
    key_valid[cur_g] = 1'b1;
    key_in[cur_g]    = kd;
    #1;
    check("rr_key_ready", b(key_ready[cur_g]), b(key_first));
    check("rr_st_ready",  b(st_ready[cur_g]), b(~key_first));
    step();
    if (key_first) begin
      key_valid[cur_g] = 1'b0;
      exp_q.push_back(sub_word(kd));
      check("rr_st_blocked", b(st_ready[cur_g]), 0);
      wait_key_done();
      check("rr_st_in_done_cycle", b(st_ready[cur_g]), 1);
      step();
      st_valid[cur_g] = 1'b0;
      exp_st = sub_state(sd);
      wait_st_done();
    end else begin
      st_valid[cur_g] = 1'b0;
      exp_st = sub_state(sd);
      for (int k = 1; k <= passes(); k++) begin
        check("rr_no_preempt", b(key_ready[cur_g]), 0);
        step();
      end
      check("rr_st_done", b(st_done[cur_g]), 1);
      check("rr_st_out",  st_out[cur_g], exp_st);
      check("rr_key_in_done_cycle", b(key_ready[cur_g]), 1);
      step();
      key_valid[cur_g] = 1'b0;
      exp_q.push_back(sub_word(kd));
      wait_key_done();
    end
  endtask

  task automatic key_mid_run();
    logic [127:0] sd = rand128();
    logic [31:0]  kd = $urandom;
    int           kr = (passes() < 2) ? passes() : 2;
    st_valid[cur_g] = 1'b1;
    st_in[cur_g]    = sd;
    step();
    st_valid[cur_g] = 1'b0;
    exp_st = sub_state(sd);
    for (int k = 1; k <= passes(); k++) begin
      check("mid_busy", b(busy[cur_g]), 1);
      if (k == kr) begin
        key_valid[cur_g] = 1'b1;
        key_in[cur_g]    = kd;
      end
      if (k >= kr) begin
        #1;
        check("mid_key_wait", b(key_ready[cur_g]), 0);
      end
      step();
    end
    check("mid_st_done", b(st_done[cur_g]), 1);
    check("mid_st_out",  st_out[cur_g], exp_st);
    check("mid_key_ready", b(key_ready[cur_g]), 1);
    step();
    key_valid[cur_g] = 1'b0;
    exp_q.push_back(sub_word(kd));
    wait_key_done();
  endtask

  task automatic reset_mid_run();
    int kr = (passes() < 3) ? passes() : 3;
    st_valid[cur_g] = 1'b1;
    st_in[cur_g]    = rand128();
    step();
    st_valid[cur_g] = 1'b0;
    for (int k = 1; k < kr; k++) step();
    check("abort_busy_before", b(busy[cur_g]), 1);
    do_reset();
    for (int k = 0; k <= passes(); k++) begin
      check("abort_no_done", b(st_done[cur_g]), 0);
      step();
    end
    run_state(rand128());
    run_key($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    st_valid  = '0;
    key_valid = '0;
    for (int g = 0; g < 3; g++) begin
      st_in[g]  = '0;
      key_in[g] = '0;
    end
    build_model();
    check("model_vector", sub_state(128'h00112233445566778899aabbccddeeff),
          128'h638293c31bfc33f5c4eeacea4bc12816);
    step();
    for (int g = 0; g < 3; g++) begin
      cur_g = g;
      do_reset();
      #1;
      check("idle_st_ready",  b(st_ready[cur_g]), 0);
      check("idle_key_ready", b(key_ready[cur_g]), 0);
      run_state(128'h00112233445566778899aabbccddeeff);
      check("st_vector", st_out[cur_g], 128'h638293c31bfc33f5c4eeacea4bc12816);
      step();
      check("st_done_pulse", b(st_done[cur_g]), 0);
      run_key(32'h09cf4f3c);
      check("key_vector", w(key_out[cur_g]), w(32'h018a84eb));
      step();
      check("key_done_pulse", b(key_done[cur_g]), 0);
      run_state(rand128());
      run_state(rand128());
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 1) == 1) run_state(rand128());
        else run_key($urandom);
      end
      do_reset();
      rr_pair(1'b1);
      rr_pair(1'b1);
      run_key($urandom);
      rr_pair(1'b0);
      step();
      key_mid_run();
      step();
      reset_mid_run();
      step();
    end
    check("exp_q_drained", b(exp_q.size() == 0), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
